// File: rtl/pipe_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard controller for a 5-stage in-order core.
//               Optional perf counters are enabled by PIPE_CTRL_PERF_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module pipe_ctrl #(
  parameter int REG_AW      = 5,
  parameter int REDIR_EXTRA = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_id_rs1_use,
  input  logic              i_id_rs2_use,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_load,
  input  logic              i_ex_redirect,
  input  logic              i_dmem_req,
  input  logic              i_dmem_ack,
  output logic              o_pc_en,
  output logic              o_id_stall,
  output logic              o_id_flush,
  output logic              o_ex_stall,
  output logic              o_ex_flush,
  output logic              o_mem_stall,
  output logic              o_wb_flush,
  output logic [1:0]        o_state,
  output logic              o_mem_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       o_stall_cycles,
  output logic [31:0]       o_flush_cycles
`endif
);

  localparam logic [1:0] c_st_run      = 2'b00;
  localparam logic [1:0] c_st_mem_wait = 2'b01;
  localparam logic [1:0] c_st_redir    = 2'b10;

  localparam int             c_wcw        = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_wcw-1:0] c_wait_max = c_wcw'(MEM_TIMEOUT);
  localparam logic [1:0]     c_redir_init = 2'(REDIR_EXTRA);

  logic [1:0]       r_state, w_state_nxt;
  logic [1:0]       r_ret_state, w_ret_nxt;
  logic [1:0]       r_redir_cnt, w_cnt_nxt;
  logic [c_wcw-1:0] r_wait_cnt, w_wait_nxt, w_wait_inc;
  logic             r_mem_timeout, w_timeout_nxt;

  logic w_mem_hold;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;
  logic w_active;

  assign w_mem_hold = i_dmem_req & ~i_dmem_ack;
  assign w_rs1_hit  = i_id_rs1_use & (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit  = i_id_rs2_use & (i_id_rs2 == i_ex_rd);
  assign w_load_use = i_ex_load & (i_ex_rd != '0) & (w_rs1_hit | w_rs2_hit);
  assign w_active   = (r_state == c_st_run) | (r_state == c_st_redir);
  assign w_wait_inc = (r_wait_cnt == c_wait_max) ? r_wait_cnt : r_wait_cnt + c_wcw'(1);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= c_st_run;
      r_ret_state   <= c_st_run;
      r_redir_cnt   <= '0;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ret_state   <= w_ret_nxt;
      r_redir_cnt   <= w_cnt_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_mem_timeout <= w_timeout_nxt;
    end
  end

  // Next-state logic; the REDIR count is untouched while parked in MEM_WAIT
  always_comb begin
    w_state_nxt   = r_state;
    w_ret_nxt     = r_ret_state;
    w_cnt_nxt     = r_redir_cnt;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_nxt = r_mem_timeout;
    case (r_state)
      c_st_run, c_st_redir: begin
        if (w_mem_hold) begin
          w_state_nxt = c_st_mem_wait;
          w_ret_nxt   = r_state;
          w_wait_nxt  = '0;
        end else if (i_ex_redirect) begin
          w_state_nxt = (REDIR_EXTRA == 0) ? c_st_run : c_st_redir;
          w_cnt_nxt   = c_redir_init;
        end else if (w_load_use) begin
          w_state_nxt = r_state;
        end else if (r_state == c_st_redir) begin
          w_cnt_nxt = (r_redir_cnt == 2'd0) ? 2'd0 : r_redir_cnt - 2'd1;
          if (r_redir_cnt <= 2'd1) begin
            w_state_nxt = c_st_run;
          end
        end
      end
      c_st_mem_wait: begin
        if (w_mem_hold) begin
          w_wait_nxt = w_wait_inc;
          if (w_wait_inc == c_wait_max) begin
            w_timeout_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = r_ret_state;
        end
      end
      default: w_state_nxt = c_st_run;
    endcase
  end

  // Output logic
  always_comb begin
    o_pc_en     = 1'b1;
    o_id_stall  = 1'b0;
    o_id_flush  = 1'b0;
    o_ex_stall  = 1'b0;
    o_ex_flush  = 1'b0;
    o_mem_stall = 1'b0;
    o_wb_flush  = 1'b0;
    if (w_mem_hold) begin
      o_pc_en     = 1'b0;
      o_id_stall  = 1'b1;
      o_ex_stall  = 1'b1;
      o_mem_stall = 1'b1;
      o_wb_flush  = 1'b1;
    end else if (w_active) begin
      if (i_ex_redirect) begin
        o_id_flush = 1'b1;
        o_ex_flush = 1'b1;
      end else if (w_load_use) begin
        o_pc_en    = 1'b0;
        o_id_stall = 1'b1;
        o_ex_flush = 1'b1;
      end else if (r_state == c_st_redir) begin
        o_id_flush = 1'b1;
      end
    end
  end

  assign o_state       = r_state;
  assign o_mem_timeout = r_mem_timeout;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_cycles;
  logic        w_any_flush;

  assign w_any_flush = o_id_flush | o_ex_flush | o_wb_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (!o_pc_en && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_any_flush && (r_flush_cycles != '1)) begin
        r_flush_cycles <= r_flush_cycles + 32'd1;
      end
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_cycles = r_flush_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// Testbench for pipe_ctrl: directed hazard sequences plus random traffic,
// checked cycle-by-cycle against a behavioural model through a scoreboard queue.
module tb_pipe_ctrl;

  localparam int AW      = 5;
  localparam int EXTRA   = 1;
  localparam int TIMEOUT = 4;
  localparam int M_RUN = 0, M_WAIT = 1, M_REDIR = 2;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rs1, rs2, rd;
  logic          rs1_use, rs2_use, ex_load, ex_redirect, dmem_req, dmem_ack;
  logic          pc_en, id_stall, id_flush, ex_stall, ex_flush, mem_stall, wb_flush;
  logic [1:0]    state;
  logic          mem_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]   stall_cycles, flush_cycles;
`endif

  pipe_ctrl #(.REG_AW(AW), .REDIR_EXTRA(EXTRA), .MEM_TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_rs1_use(rs1_use), .i_id_rs2_use(rs2_use),
    .i_ex_rd(rd), .i_ex_load(ex_load), .i_ex_redirect(ex_redirect),
    .i_dmem_req(dmem_req), .i_dmem_ack(dmem_ack),
    .o_pc_en(pc_en), .o_id_stall(id_stall), .o_id_flush(id_flush),
    .o_ex_stall(ex_stall), .o_ex_flush(ex_flush), .o_mem_stall(mem_stall),
    .o_wb_flush(wb_flush), .o_state(state), .o_mem_timeout(mem_timeout)
`ifdef PIPE_CTRL_PERF_EN
    , .o_stall_cycles(stall_cycles), .o_flush_cycles(flush_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [9:0] v;
    int         id;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_issued = 0;

  // Behavioural model: pipeline "mode", flush cycles still owed, where to go
  // back after a memory wait, how long we have waited, sticky timeout.
  int m_mode = M_RUN, m_ret = M_RUN, m_left = 0, m_waited = 0;
  bit m_to = 0;
  int m_stalls = 0, m_flushes = 0;

  task automatic issue(input bit r_n, input bit req, input bit ack, input bit redir,
                       input bit load, input bit u1, input bit u2,
                       input int a1, input int a2, input int d);
    bit hold, lu;
    bit pc, ids, idf, exs, exf, ms, wbf;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r_n; dmem_req = req; dmem_ack = ack; ex_redirect = redir;
    ex_load = load; rs1_use = u1; rs2_use = u2;
    rs1 = AW'(a1); rs2 = AW'(a2); rd = AW'(d);

    if (!r_n) begin
      m_mode = M_RUN; m_ret = M_RUN; m_left = 0; m_waited = 0; m_to = 0;
      m_stalls = 0; m_flushes = 0;
    end
    hold = req && !ack;
    lu   = load && (d != 0) && ((u1 && a1 == d) || (u2 && a2 == d));
    pc = 1; ids = 0; idf = 0; exs = 0; exf = 0; ms = 0; wbf = 0;
    if (hold) begin
      pc = 0; ids = 1; exs = 1; ms = 1; wbf = 1;
    end else if (m_mode != M_WAIT) begin
      if (redir) begin
        idf = 1; exf = 1;
      end else if (lu) begin
        pc = 0; ids = 1; exf = 1;
      end else if (m_mode == M_REDIR) begin
        idf = 1;
      end
    end
    e.v  = {pc, ids, idf, exs, exf, ms, wbf, 2'(m_mode), m_to};
    e.id = n_issued;
    q.push_back(e);
    n_issued++;

    if (r_n) begin
      if (!pc) m_stalls++;
      if (idf || exf || wbf) m_flushes++;
      if (m_mode == M_WAIT) begin
        if (hold) begin
          m_waited = (m_waited + 1 > TIMEOUT) ? TIMEOUT : m_waited + 1;
          if (m_waited >= TIMEOUT) m_to = 1;
        end else begin
          m_mode = m_ret;
        end
      end else if (hold) begin
        m_ret = m_mode; m_mode = M_WAIT; m_waited = 0;
      end else if (redir) begin
        m_left = EXTRA;
        m_mode = (EXTRA > 0) ? M_REDIR : M_RUN;
      end else if (lu) begin
        m_mode = m_mode;
      end else if (m_mode == M_REDIR) begin
        m_left = m_left - 1;
        if (m_left <= 0) begin
          m_left = 0; m_mode = M_RUN;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle with an outstanding expectation is compared at negedge
  initial begin
    exp_t e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {pc_en, id_stall, id_flush, ex_stall, ex_flush, mem_stall, wb_flush,
               state, mem_timeout};
        n_checks++;
        if (act === e.v) n_pass++;
        else $display("FAIL cyc%0d outputs{pc,ids,idf,exs,exf,ms,wbf,st,to}: got %b expected %b",
                      e.id, act, e.v);
      end
    end
  end

  initial begin
    rst_n = 0; rs1 = '0; rs2 = '0; rd = '0; rs1_use = 0; rs2_use = 0;
    ex_load = 0; ex_redirect = 0; dmem_req = 0; dmem_ack = 0;

    // Reset: idle outputs, but mem_hold still wins
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Load-use on rs1, then idle
    issue(1, 0, 0, 0, 1, 1, 0, 5, 0, 5);
    idle(1);
    // rd = x0 never stalls
    issue(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    // rs2 match only counts when rs2 is used
    issue(1, 0, 0, 0, 1, 0, 0, 1, 7, 7);
    issue(1, 0, 0, 0, 1, 0, 1, 1, 7, 7);
    // Redirect pulse then REDIR flush then RUN
    issue(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Redirect beats load-use
    issue(1, 0, 0, 1, 1, 1, 0, 3, 0, 3);
    idle(2);
    // Memory wait during REDIR, ack after 3 cycles
    issue(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) issue(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Redirect and load-use held off by a memory wait, redirect acted on afterwards
    for (int i = 0; i < 2; i++) issue(1, 1, 0, 1, 1, 1, 0, 4, 0, 4);
    issue(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Load-use inside REDIR keeps the flush owed
    issue(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 1, 0, 1, 0, 2, 2);
    idle(2);
    // Request dropped mid-wait returns to saved state
    issue(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Timeout: never acked, flag sticky until reset
    for (int i = 0; i < 7; i++) issue(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Reset in the middle of a memory wait abandons it
    issue(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    issue(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Random traffic with small register indices so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      bit r_n, req, ack;
      r_n = ($urandom_range(0, 199) != 0);
      req = ($urandom_range(0, 3) == 0) || (state == 2'b01 && $urandom_range(0, 7) != 0);
      ack = ($urandom_range(0, 2) == 0);
      issue(r_n, req, ack, $urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)));
    end
    idle(1);

    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
`ifdef PIPE_CTRL_PERF_EN
    n_checks++;
    if (stall_cycles == 32'(m_stalls)) n_pass++;
    else $display("FAIL stall_cycles: got %0d expected %0d", stall_cycles, m_stalls);
    n_checks++;
    if (flush_cycles == 32'(m_flushes)) n_pass++;
    else $display("FAIL flush_cycles: got %0d expected %0d", flush_cycles, m_flushes);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter REDIR_EXTRA, default 1 (legal 0..3), extra IF/ID flush cycles after a redirect (synchronous imem latency).
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255, MEM_WAIT cycles before timeout flag.
REQ-004 SHALL have ports, clock and reset first:
- i_clk  in  1  sole clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_id_rs1, i_id_rs2  in  REG_AW  ID-stage source registers
- i_id_rs1_use, i_id_rs2_use  in  1  source actually read by ID instruction
- i_ex_rd  in  REG_AW  EX-stage destination register
- i_ex_load  in  1  EX instruction is a load
- i_ex_redirect  in  1  EX resolved taken branch/jump or mispredict
- i_dmem_req  in  1  MEM-stage access valid
- i_dmem_ack  in  1  dmem completes access this cycle
- o_pc_en  out  1  PC update enable
- o_id_stall, o_id_flush  out  1  IF/ID register stall/flush
- o_ex_stall, o_ex_flush  out  1  ID/EX register stall/flush
- o_mem_stall  out  1  EX/MEM register stall
- o_wb_flush  out  1  MEM/WB bubble insert
- o_state  out  2  RUN=00, MEM_WAIT=01, REDIR=10
- o_mem_timeout  out  1  sticky timeout flag

Function
REQ-005 SHALL compute all stall/flush outputs combinationally from current state and inputs, zero added latency.
REQ-006 SHALL define mem_hold = i_dmem_req & ~i_dmem_ack; in any state, mem_hold forces o_pc_en=0, o_id_stall=o_ex_stall=o_mem_stall=1, o_wb_flush=1, all other flushes 0.
REQ-007 SHALL define load_use = i_ex_load & (i_ex_rd != 0) & ((i_id_rs1_use & rs1==rd) | (i_id_rs2_use & rs2==rd)).
REQ-008 Priority when not mem_hold: redirect > load_use > REDIR-state flush > idle.
REQ-009 Redirect (RUN or REDIR): o_pc_en=1, o_id_flush=1, o_ex_flush=1; next state REDIR with remaining count = REDIR_EXTRA, or RUN when REDIR_EXTRA=0.
REQ-010 Load-use (RUN or REDIR, no redirect): o_pc_en=0, o_id_stall=1, o_ex_flush=1; state and REDIR count unchanged.
REQ-011 REDIR, no redirect/load_use: o_pc_en=1, o_id_flush=1; count decrements; count reaching 0 -> RUN next cycle.
REQ-012 Idle in RUN: o_pc_en=1, every stall/flush 0.
REQ-013 mem_hold in RUN or REDIR -> MEM_WAIT, saving return state and REDIR count; i_dmem_ack -> return to saved state the next cycle, count unchanged.
REQ-014 i_ex_redirect and load_use are ignored while mem_hold; a held redirect is acted on in the first cycle after ack.
REQ-015 MEM_WAIT wait counter increments per cycle and saturates; reaching MEM_TIMEOUT sets o_mem_timeout, which stays 1 until reset; stall continues.
REQ-016 Wait counter clears on entry to MEM_WAIT.
REQ-017 i_dmem_req=0 in MEM_WAIT (illegal) SHALL return to saved state.

Reset
REQ-018 i_rst_n=0 asynchronously: state RUN, REDIR count 0, saved state RUN, wait counter 0, o_mem_timeout 0, counters 0.
REQ-019 During reset outputs SHALL show RUN/idle values (o_pc_en=1, stalls/flushes 0) unless driven otherwise by mem_hold; reset mid-REDIR or mid-MEM_WAIT abandons the sequence.

Configuration
REQ-020 Macro PIPE_CTRL_PERF_EN defined: add outputs o_stall_cycles, o_flush_cycles (32 bits each, saturating) counting cycles with o_pc_en=0 and with any flush=1 respectively.
REQ-021 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-022 ID rs1=5 used, EX load rd=5 -> one cycle o_pc_en=0, o_id_stall=1, o_ex_flush=1, then idle.
REQ-023 EX load rd=0, ID rs1=0 -> no stall.
REQ-024 Redirect pulse, REDIR_EXTRA=1 -> cycle0 id/ex flush, cycle1 id flush only, cycle2 RUN idle.
REQ-025 Redirect plus load_use same cycle -> redirect outputs only, o_pc_en=1.
REQ-026 dmem_req with ack after 3 cycles during REDIR (count 1) -> 3 full-stall cycles, state 01, then REDIR with one id flush, then RUN.
REQ-027 MEM_TIMEOUT=4, dmem never acks -> o_mem_timeout=1 after 4 wait cycles, held after ack; cleared only by i_rst_n=0.
